strait_selftest_sequencer: RTL and testbench

Multi-tile power-on self-test sequencer for STRAIT accelerators. It drives up to NUM_TILES STRAIT tiles one after another through MBIST, then LBIST (SA followed by TD), then BISR recovery. Each phase is bounded by a watchdog, and per-tile results are latched into a status vector. It sits above the tile instances and replaces the external testbench/host that currently toggles START, test_mode and BIST_mode by hand.

---
 rtl/strait_seq_pkg.sv | 65 ++++++
 rtl/strait_seq_watchdog.sv | 47 ++++
 rtl/strait_selftest_sequencer.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_strait_selftest_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/strait_seq_pkg.sv
// Shared types and helpers for the STRAIT multi-tile self-test sequencer.
// Holds the sequencer state encoding, default sizing constants, and the
// state-to-control decode used to build the registered tile controls.
package strait_seq_pkg;

    localparam int DEFAULT_NUM_TILES      = 4;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        SCAN     = 4'd1,
        SETUP_MB = 4'd2,
        START_MB = 4'd3,
        WAIT_MB  = 4'd4,
        SETUP_LB = 4'd5,
        START_LB = 4'd6,
        WAIT_SA  = 4'd7,
        WAIT_TD  = 4'd8,
        WAIT_REC = 4'd9,
        CLOSE    = 4'd10,
        DONE     = 4'd11
    } seq_state_t;

    // States in which the watchdog runs and an external tile event is awaited.
    function automatic logic is_wait_state(input seq_state_t s);
        logic r;
        case (s)
            WAIT_MB, WAIT_SA, WAIT_TD, WAIT_REC: r = 1'b1;
            default:                             r = 1'b0;
        endcase
        return r;
    endfunction

    // test_mode stays up for the whole MBIST + LBIST + recovery window.
    function automatic logic drives_test_mode(input seq_state_t s);
        logic r;
        case (s)
            SETUP_MB, START_MB, WAIT_MB,
            SETUP_LB, START_LB, WAIT_SA, WAIT_TD, WAIT_REC: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // BIST_mode selects LBIST; it is held through SA, TD and recovery.
    function automatic logic drives_bist_mode(input seq_state_t s);
        logic r;
        case (s)
            SETUP_LB, START_LB, WAIT_SA, WAIT_TD, WAIT_REC: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

    // START is a single-cycle pulse issued from the two START_* states.
    function automatic logic drives_start(input seq_state_t s);
        logic r;
        case (s)
            START_MB, START_LB: r = 1'b1;
            default:            r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/strait_seq_watchdog.sv
// Wait-state watchdog for the self-test sequencer.
// The counter is cleared on entry to a wait state and counts every cycle
// spent there; expire is high during the TIMEOUT_CYCLES-th waiting cycle,
// so the caller leaves the wait state exactly TIMEOUT_CYCLES cycles after
// entry unless the awaited event arrives first.
module strait_seq_watchdog
    import strait_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on entry, advance while waiting, saturate at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST_COUNT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && (cnt_q == LAST_COUNT);

endmodule

// File: rtl/strait_selftest_sequencer.sv
// Multi-tile power-on self-test sequencer for STRAIT accelerators.
// Walks the masked tiles in index order through MBIST, LBIST (SA then TD)
// and BISR recovery, bounding every wait with a watchdog and latching
// per-tile results. All outputs are registered; tile controls are decoded
// from the next state so test_mode always leads START by one cycle.
module strait_selftest_sequencer
    import strait_seq_pkg::*;
#(
    parameter int NUM_TILES      = DEFAULT_NUM_TILES,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int TILE_IDX_WIDTH = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      abort,
    input  logic [NUM_TILES-1:0]      tile_mask,
    input  logic [NUM_TILES-1:0]      tile_test_done,
    input  logic [NUM_TILES-1:0]      tile_MBIST_FAIL,
    input  logic [NUM_TILES-1:0]      tile_TD_error_flag,
    input  logic [NUM_TILES-1:0]      tile_recovery_done,
    input  logic [NUM_TILES-1:0]      tile_recovery_success,
    output logic [NUM_TILES-1:0]      tile_START,
    output logic [NUM_TILES-1:0]      tile_test_mode,
    output logic [NUM_TILES-1:0]      tile_BIST_mode,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [TILE_IDX_WIDTH-1:0] cur_tile,
    output logic [NUM_TILES-1:0]      tile_pass,
    output logic [NUM_TILES-1:0]      tile_mbist_fail,
    output logic [NUM_TILES-1:0]      tile_td_fail,
    output logic [NUM_TILES-1:0]      tile_timeout,
    output logic [NUM_TILES-1:0]      tile_unrecovered
);

    localparam logic [TILE_IDX_WIDTH-1:0] LAST_IDX = TILE_IDX_WIDTH'(NUM_TILES - 1);

    seq_state_t                state_q, state_d;
    logic [TILE_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [NUM_TILES-1:0]      mask_q, mask_d;
    logic [NUM_TILES-1:0]      pass_q, pass_d;
    logic [NUM_TILES-1:0]      mbist_fail_q, mbist_fail_d;
    logic [NUM_TILES-1:0]      td_fail_q, td_fail_d;
    logic [NUM_TILES-1:0]      timeout_q, timeout_d;
    logic [NUM_TILES-1:0]      unrec_q, unrec_d;
    logic                      aborted_q, aborted_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [NUM_TILES-1:0]      start_q, start_d;
    logic [NUM_TILES-1:0]      test_mode_q, test_mode_d;
    logic [NUM_TILES-1:0]      bist_mode_q, bist_mode_d;

    // Only the tile under test is listened to; the rest are ignored.
    logic sel_test_done;
    logic sel_mbist_fail;
    logic sel_td_error;
    logic sel_rec_done;
    logic sel_rec_success;

    assign sel_test_done   = tile_test_done[idx_q];
    assign sel_mbist_fail  = tile_MBIST_FAIL[idx_q];
    assign sel_td_error    = tile_TD_error_flag[idx_q];
    assign sel_rec_done    = tile_recovery_done[idx_q];
    assign sel_rec_success = tile_recovery_success[idx_q];

    logic wd_clr;
    logic wd_en;
    logic wd_expire;

    // Restart the watchdog whenever a (new) wait state is entered.
    assign wd_clr = is_wait_state(state_d) && (state_d != state_q);
    assign wd_en  = is_wait_state(state_q);

    strait_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (wd_clr),
        .en    (wd_en),
        .expire(wd_expire)
    );

    // Next-state, tile index and result bookkeeping.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        mask_d       = mask_q;
        aborted_d    = aborted_q;
        pass_d       = pass_q;
        mbist_fail_d = mbist_fail_q;
        td_fail_d    = td_fail_q;
        timeout_d    = timeout_q;
        unrec_d      = unrec_q;

        case (state_q)
            IDLE: begin
                // A start that coincides with abort is dropped.
                if (start && !abort) begin
                    mask_d       = tile_mask;
                    pass_d       = '0;
                    mbist_fail_d = '0;
                    td_fail_d    = '0;
                    timeout_d    = '0;
                    unrec_d      = '0;
                    aborted_d    = 1'b0;
                    idx_d        = '0;
                    state_d      = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                if (abort) begin
                    // Results of the tile in progress stay as they are.
                    aborted_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    case (state_q)
                        SCAN: begin
                            if (mask_q[idx_q]) begin
                                state_d = SETUP_MB;
                            end else if (idx_q == LAST_IDX) begin
                                state_d = DONE;
                            end else begin
                                idx_d   = idx_q + TILE_IDX_WIDTH'(1);
                                state_d = SCAN;
                            end
                        end

                        SETUP_MB: state_d = START_MB;
                        START_MB: state_d = WAIT_MB;

                        WAIT_MB: begin
                            if (sel_test_done) begin
                                if (sel_mbist_fail) begin
                                    // A tile that fails memory test skips LBIST.
                                    mbist_fail_d[idx_q] = 1'b1;
                                    state_d             = CLOSE;
                                end else begin
                                    state_d = SETUP_LB;
                                end
                            end else if (wd_expire) begin
                                timeout_d[idx_q] = 1'b1;
                                state_d          = CLOSE;
                            end else begin
                                state_d = WAIT_MB;
                            end
                        end

                        SETUP_LB: state_d = START_LB;
                        START_LB: state_d = WAIT_SA;

                        WAIT_SA: begin
                            if (sel_test_done) begin
                                state_d = WAIT_TD;
                            end else if (wd_expire) begin
                                timeout_d[idx_q] = 1'b1;
                                state_d          = CLOSE;
                            end else begin
                                state_d = WAIT_SA;
                            end
                        end

                        WAIT_TD: begin
                            if (sel_test_done) begin
                                td_fail_d[idx_q] = sel_td_error;
                                state_d          = WAIT_REC;
                            end else if (wd_expire) begin
                                timeout_d[idx_q] = 1'b1;
                                state_d          = CLOSE;
                            end else begin
                                state_d = WAIT_TD;
                            end
                        end

                        WAIT_REC: begin
                            if (sel_rec_done) begin
                                unrec_d[idx_q] = ~sel_rec_success;
                                state_d        = CLOSE;
                            end else if (wd_expire) begin
                                timeout_d[idx_q] = 1'b1;
                                state_d          = CLOSE;
                            end else begin
                                state_d = WAIT_REC;
                            end
                        end

                        CLOSE: begin
                            // A TD error alone does not fail a tile that recovered.
                            pass_d[idx_q] = ~mbist_fail_q[idx_q] & ~timeout_q[idx_q]
                                          & ~unrec_q[idx_q];
                            if (idx_q == LAST_IDX) begin
                                state_d = DONE;
                            end else begin
                                idx_d   = idx_q + TILE_IDX_WIDTH'(1);
                                state_d = SCAN;
                            end
                        end

                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        start_d     = '0;
        test_mode_d = '0;
        bist_mode_d = '0;
        if (drives_start(state_d)) begin
            start_d[idx_d] = 1'b1;
        end else begin
            start_d = '0;
        end
        if (drives_test_mode(state_d)) begin
            test_mode_d[idx_d] = 1'b1;
        end else begin
            test_mode_d = '0;
        end
        if (drives_bist_mode(state_d)) begin
            bist_mode_d[idx_d] = 1'b1;
        end else begin
            bist_mode_d = '0;
        end
        busy_d = (state_d != IDLE);
        // done follows the DONE state, coinciding with busy falling.
        done_d = (state_q == DONE);
    end

    // State, index, result and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            mask_q       <= '0;
            pass_q       <= '0;
            mbist_fail_q <= '0;
            td_fail_q    <= '0;
            timeout_q    <= '0;
            unrec_q      <= '0;
            aborted_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_q      <= '0;
            test_mode_q  <= '0;
            bist_mode_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            mask_q       <= mask_d;
            pass_q       <= pass_d;
            mbist_fail_q <= mbist_fail_d;
            td_fail_q    <= td_fail_d;
            timeout_q    <= timeout_d;
            unrec_q      <= unrec_d;
            aborted_q    <= aborted_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_q      <= start_d;
            test_mode_q  <= test_mode_d;
            bist_mode_q  <= bist_mode_d;
        end
    end

    assign tile_START       = start_q;
    assign tile_test_mode   = test_mode_q;
    assign tile_BIST_mode   = bist_mode_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign aborted          = aborted_q;
    assign cur_tile         = idx_q;
    assign tile_pass        = pass_q;
    assign tile_mbist_fail  = mbist_fail_q;
    assign tile_td_fail     = td_fail_q;
    assign tile_timeout     = timeout_q;
    assign tile_unrecovered = unrec_q;

endmodule

// File: tb/tb_strait_selftest_sequencer.sv
// Directed self-checking bench for strait_selftest_sequencer (4 tiles,
// 64-cycle watchdog). Behavioural tile models answer START pulses; a
// monitor records control activity; the main sequence checks results.
module tb_strait_selftest_sequencer;

    localparam int NT = 4;
    localparam int TO = 64;
    localparam int IW = 2;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic [NT-1:0] tile_mask;
    logic [NT-1:0] tile_test_done;
    logic [NT-1:0] tile_MBIST_FAIL;
    logic [NT-1:0] tile_TD_error_flag;
    logic [NT-1:0] tile_recovery_done;
    logic [NT-1:0] tile_recovery_success;
    logic [NT-1:0] tile_START;
    logic [NT-1:0] tile_test_mode;
    logic [NT-1:0] tile_BIST_mode;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [IW-1:0] cur_tile;
    logic [NT-1:0] tile_pass;
    logic [NT-1:0] tile_mbist_fail;
    logic [NT-1:0] tile_td_fail;
    logic [NT-1:0] tile_timeout;
    logic [NT-1:0] tile_unrecovered;

    strait_selftest_sequencer #(
        .NUM_TILES(NT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .tile_mask            (tile_mask),
        .tile_test_done       (tile_test_done),
        .tile_MBIST_FAIL      (tile_MBIST_FAIL),
        .tile_TD_error_flag   (tile_TD_error_flag),
        .tile_recovery_done   (tile_recovery_done),
        .tile_recovery_success(tile_recovery_success),
        .tile_START           (tile_START),
        .tile_test_mode       (tile_test_mode),
        .tile_BIST_mode       (tile_BIST_mode),
        .busy                 (busy),
        .done                 (done),
        .aborted              (aborted),
        .cur_tile             (cur_tile),
        .tile_pass            (tile_pass),
        .tile_mbist_fail      (tile_mbist_fail),
        .tile_td_fail         (tile_td_fail),
        .tile_timeout         (tile_timeout),
        .tile_unrecovered     (tile_unrecovered)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter; read half a cycle after the rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Tile model configuration (written only by the main sequence).
    logic [NT-1:0] cfg_mb_fail;
    logic [NT-1:0] cfg_td_err;
    logic [NT-1:0] cfg_rec_bad;
    logic [NT-1:0] cfg_td_hang;
    int            cfg_td_delay [NT];

    // Tile model state.
    int ph     [NT];
    int tmr    [NT];
    int sa_cyc [NT];

    // Tile models: each phase answers 10 cycles after it starts (TD phase configurable).
    always @(negedge clk) begin
        for (int i = 0; i < NT; i++) begin
            tile_test_done[i]        = 1'b0;
            tile_MBIST_FAIL[i]       = 1'b0;
            tile_TD_error_flag[i]    = 1'b0;
            tile_recovery_done[i]    = 1'b0;
            tile_recovery_success[i] = 1'b0;
            if (!rst_n) begin
                ph[i]  = 0;
                tmr[i] = 0;
            end else if (tile_START[i]) begin
                ph[i]  = tile_BIST_mode[i] ? 2 : 1;
                tmr[i] = 10;
            end else if (ph[i] != 0) begin
                tmr[i] = tmr[i] - 1;
                if (tmr[i] == 0) begin
                    case (ph[i])
                        1: begin
                            tile_test_done[i]  = 1'b1;
                            tile_MBIST_FAIL[i] = cfg_mb_fail[i];
                            ph[i]              = 0;
                        end
                        2: begin
                            tile_test_done[i] = 1'b1;
                            sa_cyc[i]         = cyc;
                            if (cfg_td_hang[i]) begin
                                ph[i] = 0;
                            end else begin
                                ph[i]  = 3;
                                tmr[i] = cfg_td_delay[i];
                            end
                        end
                        3: begin
                            tile_test_done[i]     = 1'b1;
                            tile_TD_error_flag[i] = cfg_td_err[i];
                            ph[i]                 = 4;
                            tmr[i]                = 10;
                        end
                        default: begin
                            tile_recovery_done[i]    = 1'b1;
                            tile_recovery_success[i] = ~cfg_rec_bad[i];
                            ph[i]                    = 0;
                        end
                    endcase
                end
            end
        end
    end

    // Monitor: control activity per sequence, done pulses, control rule violations.
    logic          busy_prev = 1'b0;
    logic          to2_prev  = 1'b0;
    logic [NT-1:0] tm_prev    = '0;
    logic [NT-1:0] start_seen = '0;
    logic [NT-1:0] bist_seen  = '0;
    logic [NT-1:0] ctrl;
    int            done_cnt = 0;
    int            viol     = 0;
    int            to2_cyc  = -1;

    always @(negedge clk) begin
        if (busy && !busy_prev) begin
            start_seen = tile_START;
            bist_seen  = tile_BIST_mode;
        end else begin
            start_seen = start_seen | tile_START;
            bist_seen  = bist_seen | tile_BIST_mode;
        end
        if (done) done_cnt++;
        ctrl = tile_START | tile_test_mode | tile_BIST_mode;
        if ((ctrl & (ctrl - 4'd1)) != 4'd0) viol++;
        if ((tile_START & ~tm_prev) != 4'd0) viol++;
        if ((tile_BIST_mode & ~tile_test_mode) != 4'd0) viol++;
        if (tile_timeout[2] && !to2_prev) to2_cyc = cyc;
        to2_prev  = tile_timeout[2];
        tm_prev   = tile_test_mode;
        busy_prev = busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_defaults();
        cfg_mb_fail = '0;
        cfg_td_err  = '0;
        cfg_rec_bad = '0;
        cfg_td_hang = '0;
        for (int i = 0; i < NT; i++) cfg_td_delay[i] = 10;
    endtask

    task automatic begin_seq(input logic [NT-1:0] m, output int t0);
        tick();
        start     = 1'b1;
        tile_mask = m;
        t0        = cyc;
        tick();
        start     = 1'b0;
        tile_mask = '0;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                dc = cyc;
                break;
            end
            tick();
        end
        check("done_within_budget", 32'(dc >= 0), 32'd1);
    endtask

    task automatic chk_res(input string pfx, input logic [NT-1:0] p, input logic [NT-1:0] mb,
                           input logic [NT-1:0] td, input logic [NT-1:0] to,
                           input logic [NT-1:0] ur);
        check({pfx, ".pass"}, 32'(tile_pass), 32'(p));
        check({pfx, ".mbist_fail"}, 32'(tile_mbist_fail), 32'(mb));
        check({pfx, ".td_fail"}, 32'(tile_td_fail), 32'(td));
        check({pfx, ".timeout"}, 32'(tile_timeout), 32'(to));
        check({pfx, ".unrecovered"}, 32'(tile_unrecovered), 32'(ur));
    endtask

    initial begin
        int t0;
        int dc;
        int d0;

        set_defaults();
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        tile_mask = '0;
        tick();
        tick();

        // Reset state
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.aborted", 32'(aborted), 32'd0);
        check("rst.cur_tile", 32'(cur_tile), 32'd0);
        check("rst.controls", 32'(tile_START | tile_test_mode | tile_BIST_mode), 32'd0);
        chk_res("rst", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst_n = 1'b1;
        tick();

        // All four tiles pass; check start-up latency
        begin_seq(4'b1111, t0);
        check("t1.busy_t1", 32'(busy), 32'd1);
        check("t1.test_mode_t1", 32'(tile_test_mode), 32'd0);
        tick();
        check("t1.test_mode_t2", 32'(tile_test_mode), 32'b0001);
        check("t1.start_t2", 32'(tile_START), 32'd0);
        check("t1.cur_tile_t2", 32'(cur_tile), 32'd0);
        tick();
        check("t1.start_t3", 32'(tile_START), 32'b0001);
        d0 = done_cnt;
        wait_done(2000, dc);
        check("t1.busy_at_done", 32'(busy), 32'd0);
        check("t1.aborted", 32'(aborted), 32'd0);
        chk_res("t1", 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        tick();
        check("t1.done_one_cycle", 32'(done), 32'd0);
        check("t1.done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1.pass_holds", 32'(tile_pass), 32'b1111);

        // Reset with no sequence running clears the latched results
        rst_n = 1'b0;
        tick();
        check("rst2.pass_cleared", 32'(tile_pass), 32'd0);
        rst_n = 1'b1;
        tick();

        // Tile 1 fails MBIST and must never see LBIST
        cfg_mb_fail = 4'b0010;
        begin_seq(4'b1111, t0);
        wait_done(2000, dc);
        chk_res("t2", 4'b1101, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        check("t2.bist_seen", 32'(bist_seen), 32'b1101);
        set_defaults();

        // Tile 2 never sends its TD completion: timeout 64 cycles into WAIT_TD
        cfg_td_hang = 4'b0100;
        begin_seq(4'b1111, t0);
        wait_done(2000, dc);
        chk_res("t3", 4'b1011, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        check("t3.timeout_latency", 32'(to2_cyc - sa_cyc[2]), 32'd65);
        check("t3.start_seen", 32'(start_seen), 32'b1111);
        set_defaults();

        // Partial mask: tiles 0 and 2 untouched
        begin_seq(4'b1010, t0);
        wait_done(2000, dc);
        check("t4.start_seen", 32'(start_seen), 32'b1010);
        chk_res("t4", 4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

        // Empty mask: done six cycles after start
        begin_seq(4'b0000, t0);
        check("t5.busy_t1", 32'(busy), 32'd1);
        wait_done(20, dc);
        check("t5.done_latency", 32'(dc - t0), 32'd6);
        check("t5.pass", 32'(tile_pass), 32'd0);
        check("t5.start_seen", 32'(start_seen), 32'd0);

        // Abort in WAIT_SA of tile 0, with a start pulse ignored while busy
        begin_seq(4'b1111, t0);
        for (int i = 0; i < 9; i++) tick();
        start     = 1'b1;
        tile_mask = 4'b0000;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("t6.tm_in_wait_sa", 32'(tile_test_mode), 32'b0001);
        check("t6.bm_in_wait_sa", 32'(tile_BIST_mode), 32'b0001);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6.controls_off", 32'(tile_START | tile_test_mode | tile_BIST_mode), 32'd0);
        check("t6.aborted", 32'(aborted), 32'd1);
        tick();
        check("t6.done", 32'(done), 32'd1);
        check("t6.busy_low", 32'(busy), 32'd0);
        check("t6.pass", 32'(tile_pass), 32'd0);
        tick();
        tick();
        check("t6.stays_idle", 32'(busy), 32'd0);
        check("t6.aborted_holds", 32'(aborted), 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6.aborted_reset", 32'(aborted), 32'd0);
        rst_n = 1'b1;
        tick();

        // TD completion coincides with watchdog expiry; tile 3 unrecovered with TD error
        cfg_td_delay[3] = 64;
        cfg_td_err      = 4'b1000;
        cfg_rec_bad     = 4'b1000;
        begin_seq(4'b1000, t0);
        wait_done(2000, dc);
        chk_res("t7", 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
        set_defaults();

        // Reset in the middle of a sequence
        begin_seq(4'b1111, t0);
        for (int i = 0; i < 4; i++) tick();
        check("t8.active_before", 32'(tile_test_mode), 32'b0001);
        rst_n = 1'b0;
        tick();
        check("t8.busy", 32'(busy), 32'd0);
        check("t8.controls", 32'(tile_START | tile_test_mode | tile_BIST_mode), 32'd0);
        rst_n = 1'b1;
        tick();

        check("control_rules", 32'(viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
